// File: rtl/md_pkg.sv
// Shared types and constants for the MD register / memory-cycle sequencer.
// Holds the sequencer state type, default NXM timeout and counter width.
package md_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RDREQ  = 2'd1,
    RDLOAD = 2'd2,
    WRREQ  = 2'd3
  } md_state_t;

  localparam int DEF_TIMEOUT = 255;
  localparam int CNT_W       = 16;

endpackage

// File: rtl/md_parity.sv
// 32-bit odd-parity generator: par makes the total count of ones odd.
// Ports: data (32-bit word in), par (odd parity bit out).
module md_parity (
  input  logic [31:0] data,
  output logic        par
);

  assign par = ~^data;

endmodule

// File: rtl/md_ctl.sv
// MD register and memory read/write cycle sequencer with NXM timeout.
// Ports: clk, reset_n, mds/destmd/srcmd/memrd/memwr/bus_ack/bus_par/nxm_clr
// in; md, mdsel, loadmd, memdrive, memrq, wrcyc, mwait, md_par, nxm,
// par_err out. Macro MD_PARITY_EN enables md_par and read-parity checking.
module md_ctl
  import md_pkg::*;
#(
  parameter int TIMEOUT = DEF_TIMEOUT
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [31:0] mds,
  input  logic        destmd,
  input  logic        srcmd,
  input  logic        memrd,
  input  logic        memwr,
  input  logic        bus_ack,
  input  logic        bus_par,
  input  logic        nxm_clr,
  output logic [31:0] md,
  output logic        mdsel,
  output logic        loadmd,
  output logic        memdrive,
  output logic        memrq,
  output logic        wrcyc,
  output logic        mwait,
  output logic        md_par,
  output logic        nxm,
  output logic        par_err
);

  localparam logic [CNT_W-1:0] TO = CNT_W'(TIMEOUT);

  md_state_t        state;
  md_state_t        state_nxt;
  logic [CNT_W-1:0] cnt;
  logic             idle;
  logic             rd_busy;
  logic             to_hit;
  logic             md_ld;

  assign idle     = (state == IDLE);
  assign rd_busy  = (state == RDREQ) | (state == RDLOAD);
  assign loadmd   = (state == RDLOAD);
  assign wrcyc    = (state == WRREQ);
  assign memdrive = (state == WRREQ);
  assign memrq    = (state == RDREQ) | (state == WRREQ);
  assign mdsel    = destmd & ~loadmd;
  assign md_ld    = mdsel | loadmd;

  // Ack wins over an expiring counter in the same cycle.
  assign to_hit = memrq & ~bus_ack & (cnt == TO);

  assign mwait = ((memrd | memwr) & ~idle)
               | ((srcmd | destmd) & rd_busy)
               | (destmd & wrcyc);

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: begin
        if (memrd)      state_nxt = RDREQ;
        else if (memwr) state_nxt = WRREQ;
      end
      RDREQ: begin
        if (bus_ack)     state_nxt = RDLOAD;
        else if (to_hit) state_nxt = IDLE;
      end
      RDLOAD: state_nxt = IDLE;
      WRREQ: begin
        if (bus_ack | to_hit) state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  // Held at zero while idle, so every new cycle starts from zero.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)                     cnt <= '0;
    else if (idle)                    cnt <= '0;
    else if (!bus_ack && cnt != '1)   cnt <= cnt + 1'b1;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)   md <= '0;
    else if (md_ld) md <= mds;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)    nxm <= 1'b0;
    else if (nxm_clr) nxm <= 1'b0;
    else if (to_hit)  nxm <= 1'b1;
  end

`ifdef MD_PARITY_EN
  logic mds_par;

  md_parity u_par (
    .data (mds),
    .par  (mds_par)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)   md_par <= 1'b1;
    else if (md_ld) md_par <= mds_par;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)     par_err <= 1'b0;
    else if (nxm_clr) par_err <= 1'b0;
    else if (loadmd && (bus_par != mds_par))
      par_err <= 1'b1;
  end
`else
  logic unused_par;
  assign unused_par = bus_par;
  assign md_par     = 1'b0;
  assign par_err    = 1'b0;
`endif

endmodule

// File: tb/tb_md_ctl.sv
// Self-checking bench for md_ctl: vector table, corner sequences and
// random traffic against a transaction-level reference model.
module tb_md_ctl;

  localparam int TO = 4;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [31:0] mds, ob, bus_data, md;
  logic        destmd, srcmd, memrd, memwr, bus_ack, bus_par, nxm_clr;
  logic        mdsel, loadmd, memdrive, memrq, wrcyc, mwait;
  logic        md_par, nxm, par_err;

  int checks = 0;
  int errors = 0;

  // Memory data selector in front of MD.
  assign mds = loadmd ? bus_data : (mdsel ? ob : md);

  always #5 clk = ~clk;

  md_ctl #(.TIMEOUT(TO)) dut (
    .clk(clk), .reset_n(reset_n), .mds(mds), .destmd(destmd),
    .srcmd(srcmd), .memrd(memrd), .memwr(memwr), .bus_ack(bus_ack),
    .bus_par(bus_par), .nxm_clr(nxm_clr), .md(md), .mdsel(mdsel),
    .loadmd(loadmd), .memdrive(memdrive), .memrq(memrq), .wrcyc(wrcyc),
    .mwait(mwait), .md_par(md_par), .nxm(nxm), .par_err(par_err)
  );

  task automatic chk1(string nm, logic act, logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %b want %b", nm, act, exp);
    end
  endtask

  task automatic chk32(string nm, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h want %h", nm, act, exp);
    end
  endtask

  task automatic clr_in();
    destmd = 0; srcmd = 0; memrd = 0; memwr = 0;
    bus_ack = 0; bus_par = 0; nxm_clr = 0;
    ob = '0;
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  function automatic logic odd_par(logic [31:0] v);
    return ($countones(v) % 2) == 0;
  endfunction

  // ctl = {memrd, memwr, destmd, srcmd, bus_ack}
  // exp = {memrq, loadmd, memdrive, mwait}
  typedef struct {
    logic [4:0]  ctl;
    logic [31:0] obv;
    logic [31:0] bus;
    logic [3:0]  exp;
    logic [31:0] e_md;
  } vec_t;

  function automatic vec_t mk(logic [4:0] c, logic [31:0] o,
                              logic [31:0] b, logic [3:0] e,
                              logic [31:0] m);
    vec_t v;
    v.ctl = c; v.obv = o; v.bus = b; v.exp = e; v.e_md = m;
    return v;
  endfunction

  task automatic do_read(logic [31:0] data, logic par);
    bus_data = data; bus_par = par;
    memrd = 1; tick();
    memrd = 0; bus_ack = 1; tick();
    bus_ack = 0; tick();
  endtask

  // Reference model: cycle flags derived from the operation rules.
  bit          m_rd, m_ld, m_wr, m_nxm, m_perr, m_par;
  logic [31:0] m_md;
  int          m_cnt;

  task automatic model_reset();
    m_rd = 0; m_ld = 0; m_wr = 0; m_nxm = 0; m_perr = 0;
    m_par = 1; m_md = '0; m_cnt = 0;
  endtask

  vec_t tbl[$];

  initial begin
    clr_in();
    bus_data = '0;
    reset_n = 0;
    repeat (2) @(negedge clk);
    #1;
    chk32("rst_md", md, 32'h0);
    chk1("rst_memrq", memrq, 1'b0);
    chk1("rst_loadmd", loadmd, 1'b0);
    chk1("rst_mwait", mwait, 1'b0);
    chk1("rst_nxm", nxm, 1'b0);
`ifdef MD_PARITY_EN
    chk1("rst_md_par", md_par, 1'b1);
`else
    chk1("rst_md_par", md_par, 1'b0);
`endif
    reset_n = 1;
    @(negedge clk);

    // Read, write, simultaneous request and held-write vectors.
    tbl.push_back(mk(5'b10000, 0, 32'h12345678, 4'b0000, 32'h0));
    tbl.push_back(mk(5'b00010, 0, 32'h12345678, 4'b1001, 32'h0));
    tbl.push_back(mk(5'b00010, 0, 32'h12345678, 4'b1001, 32'h0));
    tbl.push_back(mk(5'b00011, 0, 32'h12345678, 4'b1001, 32'h0));
    tbl.push_back(mk(5'b00010, 0, 32'h12345678, 4'b0101, 32'h0));
    tbl.push_back(mk(5'b00010, 0, 32'h12345678, 4'b0000, 32'h12345678));
    tbl.push_back(mk(5'b00100, 32'hDEADBEEF, 32'h12345678, 4'b0000,
                     32'h12345678));
    tbl.push_back(mk(5'b01000, 0, 32'h12345678, 4'b0000, 32'hDEADBEEF));
    tbl.push_back(mk(5'b00000, 0, 32'h12345678, 4'b1010, 32'hDEADBEEF));
    tbl.push_back(mk(5'b00001, 0, 32'h12345678, 4'b1010, 32'hDEADBEEF));
    tbl.push_back(mk(5'b00000, 0, 32'h12345678, 4'b0000, 32'hDEADBEEF));
    tbl.push_back(mk(5'b11000, 0, 32'hCAFEF00D, 4'b0000, 32'hDEADBEEF));
    tbl.push_back(mk(5'b01000, 0, 32'hCAFEF00D, 4'b1001, 32'hDEADBEEF));
    tbl.push_back(mk(5'b01001, 0, 32'hCAFEF00D, 4'b1001, 32'hDEADBEEF));
    tbl.push_back(mk(5'b01000, 0, 32'hCAFEF00D, 4'b0101, 32'hDEADBEEF));
    tbl.push_back(mk(5'b01000, 0, 32'hCAFEF00D, 4'b0000, 32'hCAFEF00D));
    tbl.push_back(mk(5'b00000, 0, 32'hCAFEF00D, 4'b1010, 32'hCAFEF00D));
    tbl.push_back(mk(5'b00001, 0, 32'hCAFEF00D, 4'b1010, 32'hCAFEF00D));
    tbl.push_back(mk(5'b00000, 0, 32'hCAFEF00D, 4'b0000, 32'hCAFEF00D));

    foreach (tbl[i]) begin
      {memrd, memwr, destmd, srcmd, bus_ack} = tbl[i].ctl;
      ob = tbl[i].obv;
      bus_data = tbl[i].bus;
      #1;
      chk1($sformatf("v%0d_memrq", i), memrq, tbl[i].exp[3]);
      chk1($sformatf("v%0d_loadmd", i), loadmd, tbl[i].exp[2]);
      chk1($sformatf("v%0d_memdrive", i), memdrive, tbl[i].exp[1]);
      chk1($sformatf("v%0d_wrcyc", i), wrcyc, tbl[i].exp[1]);
      chk1($sformatf("v%0d_mwait", i), mwait, tbl[i].exp[0]);
      chk32($sformatf("v%0d_md", i), md, tbl[i].e_md);
      if (tbl[i].exp[1])
        chk32($sformatf("v%0d_mds", i), mds, tbl[i].e_md);
      tick();
    end
    clr_in();

    // Timeout: nxm rises TO+1 cycles after memrq.
    memrd = 1; tick();
    memrd = 0;
    for (int k = 1; k <= TO + 1; k++) begin
      #1;
      chk1($sformatf("to%0d_memrq", k), memrq, 1'b1);
      chk1($sformatf("to%0d_nxm", k), nxm, 1'b0);
      tick();
    end
    #1;
    chk1("to_nxm", nxm, 1'b1);
    chk1("to_memrq", memrq, 1'b0);
    chk32("to_md", md, 32'hCAFEF00D);
    nxm_clr = 1; tick();
    nxm_clr = 0; #1;
    chk1("to_nxm_clr", nxm, 1'b0);

    // Read parity.
    @(negedge clk);
    do_read(32'h00000001, 1'b1);
    #1;
    chk32("p1_md", md, 32'h1);
`ifdef MD_PARITY_EN
    chk1("p1_md_par", md_par, 1'b0);
    chk1("p1_par_err", par_err, 1'b1);
`else
    chk1("p1_md_par", md_par, 1'b0);
    chk1("p1_par_err", par_err, 1'b0);
`endif
    nxm_clr = 1; tick();
    nxm_clr = 0;
    do_read(32'h00000003, 1'b1);
    #1;
    chk32("p3_md", md, 32'h3);
    chk1("p3_par_err", par_err, 1'b0);
`ifdef MD_PARITY_EN
    chk1("p3_md_par", md_par, 1'b1);
`else
    chk1("p3_md_par", md_par, 1'b0);
`endif
    clr_in();
    @(negedge clk);

    // Reset in the middle of a read.
    memrd = 1; tick();
    memrd = 0; #1;
    chk1("mr_memrq_pre", memrq, 1'b1);
    reset_n = 0; #1;
    chk1("mr_memrq", memrq, 1'b0);
    chk32("mr_md", md, 32'h0);
    @(negedge clk);
    reset_n = 1;
    @(negedge clk);
    do_read(32'h0BADF00D, 1'b0);
    #1;
    chk32("mr_after_md", md, 32'h0BADF00D);

    // Random traffic against the model.
    clr_in();
    reset_n = 0; #1;
    model_reset();
    @(negedge clk);
    reset_n = 1;
    for (int n = 0; n < 2000; n++) begin
      bit          idl, e_sel, e_wait, e_perr_set, e_to;
      logic [31:0] v;
      memrd    = ($urandom_range(0, 4) == 0);
      memwr    = ($urandom_range(0, 4) == 0);
      destmd   = ($urandom_range(0, 4) == 0);
      srcmd    = ($urandom_range(0, 3) == 0);
      bus_ack  = ($urandom_range(0, 9) < 3);
      bus_par  = ($urandom_range(0, 1) == 1);
      nxm_clr  = ($urandom_range(0, 19) == 0);
      ob       = $urandom();
      bus_data = $urandom();
      #1;
      idl    = !(m_rd || m_ld || m_wr);
      e_sel  = destmd && !m_ld;
      e_wait = ((memrd || memwr) && !idl) ||
               ((srcmd || destmd) && (m_rd || m_ld)) ||
               (destmd && m_wr);
      chk1("r_memrq", memrq, m_rd || m_wr);
      chk1("r_wrcyc", wrcyc, m_wr);
      chk1("r_loadmd", loadmd, m_ld);
      chk1("r_mdsel", mdsel, e_sel);
      chk1("r_mwait", mwait, e_wait);
      chk32("r_md", md, m_md);
      chk1("r_nxm", nxm, m_nxm);
`ifdef MD_PARITY_EN
      chk1("r_md_par", md_par, m_par);
      chk1("r_par_err", par_err, m_perr);
`else
      chk1("r_md_par", md_par, 1'b0);
      chk1("r_par_err", par_err, 1'b0);
`endif
      v = m_ld ? bus_data : (e_sel ? ob : m_md);
      e_perr_set = m_ld && (bus_par != odd_par(bus_data));
      e_to = (m_rd || m_wr) && !bus_ack && (m_cnt == TO);
      if (m_ld || e_sel) begin
        m_md  = v;
        m_par = odd_par(v);
      end
      if (nxm_clr) begin
        m_nxm = 0; m_perr = 0;
      end else begin
        if (e_to) m_nxm = 1;
        if (e_perr_set) m_perr = 1;
      end
      if (idl) begin
        m_cnt = 0;
        if (memrd) m_rd = 1;
        else if (memwr) m_wr = 1;
      end else if (m_ld) begin
        m_ld = 0;
      end else if (bus_ack) begin
        m_ld = m_rd;
        m_rd = 0; m_wr = 0;
      end else if (e_to) begin
        m_rd = 0; m_wr = 0;
      end else begin
        m_cnt++;
      end
      tick();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/md_ctl.md
# md_ctl

Memory data register (MD) and memory-cycle sequencer for the CADR main-memory path. It holds the 32-bit MD register, which it loads from the memory data selector's `mds` output, and sequences read and write cycles against the bus interface. It generates the `loadmd`, `memdrive` and `mdsel` selects that steer the selector, and stalls the microcode while a cycle is pending.

## Interface
Parameters:
- TIMEOUT, 255: cycles to wait for `bus_ack` before declaring non-existent memory (NXM); range 1..65535.

Ports:
- clk  input  1  system clock; all state changes on its rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- mds  input  32  memory data selector output; D input of the MD register.
- destmd  input  1  microinstruction writes MD from `ob` this cycle.
- srcmd  input  1  microinstruction reads MD this cycle.
- memrd  input  1  request to start a memory read.
- memwr  input  1  request to start a memory write of current MD.
- bus_ack  input  1  bus interface completes the current cycle (read data valid on bus).
- bus_par  input  1  odd parity of the bus read data.
- nxm_clr  input  1  clears the sticky `nxm` and `par_err` flags.
- md  output  32  MD register.
- mdsel  output  1  selector picks `ob`.
- loadmd  output  1  selector picks the bus data; MD loads it.
- memdrive  output  1  write cycle in progress; selector drives MD.
- memrq  output  1  bus request, high from cycle start until ack or timeout.
- wrcyc  output  1  current `memrq` is a write.
- mwait  output  1  microcode stall.
- md_par  output  1  odd parity of `md`.
- nxm  output  1  sticky NXM timeout flag.
- par_err  output  1  sticky read-parity error flag.

## Operation
- States: IDLE, RDREQ, RDLOAD, WRREQ.
- **IDLE:**
  - `memrd` moves the block to RDREQ.
  - Otherwise `memwr` moves it to WRREQ.
  - If both are high, the read wins and the write is dropped; there is no queue.
- **RDREQ:**
  - `memrq` is 1 and `wrcyc` is 0.
  - `bus_ack` moves the block to RDLOAD.
  - If the timeout counter reaches TIMEOUT first, set `nxm` and go to IDLE with MD unchanged.
- **RDLOAD:** lasts one cycle.
  - `loadmd` is 1.
  - MD loads `mds`, which equals the bus data.
  - Then go to IDLE.
- **WRREQ:**
  - `memrq`, `wrcyc` and `memdrive` are 1.
  - `bus_ack` returns the block to IDLE.
  - On timeout, set `nxm` and return to IDLE.
- **Selects and MD load:**
  - `mdsel` = `destmd` & (state is not RDLOAD).
  - MD loads `mds` when `mdsel` or `loadmd` is high.
  - `loadmd` has priority: `destmd` during RDLOAD is stalled, not merged.
- **`mwait` is high when any of:**
  - `memrd` or `memwr` is presented outside IDLE; the request is not accepted and must be held.
  - `srcmd` or `destmd` is presented in RDREQ or RDLOAD.
  - `destmd` is presented in WRREQ.
- **Timeout counter:**
  - 16-bit; cleared on entry to RDREQ or WRREQ.
  - Increments each cycle without `bus_ack`.
  - Saturates; no wrap.
- **Flags:**
  - `bus_ack` outside RDREQ/WRREQ is ignored.
  - `nxm_clr` has priority over a same-cycle set.
- **Reset:**
  - All outputs 0, MD = 0, state IDLE, counter 0, `md_par` = 1 (odd parity of zero).
  - Reset mid-cycle abandons the bus cycle immediately; `memrq` drops asynchronously.

## Timing
- Read latency:
  - `memrd` accepted in cycle N; `memrq` is high from cycle N+1.
  - `bus_ack` in cycle M; `loadmd` is high in cycle M+1.
  - New MD is visible in cycle M+2, and `mwait` drops in M+2.
- Minimum read (ack in N+1): data in MD at N+3; back-to-back read accepted at N+3.
- Write: `memrq` and `memdrive` are high from N+1 through the ack cycle; the next request is accepted the cycle after the ack.
- Timeout: `nxm` rises TIMEOUT+1 cycles after `memrq` first rises.
- `destmd` in IDLE: MD updates at the next edge, with no stall.

## Configuration
- Macro `MD_PARITY_EN`.
- Defined:
  - `md_par` is registered alongside MD, as odd parity of the loaded value.
  - In RDLOAD, if `bus_par` ≠ odd parity of `mds`, set `par_err`.
- Undefined:
  - `md_par` and `par_err` are tied to 0.
  - `bus_par` is ignored.
  - Ports remain present.

## Structure
- Package `md_pkg`:
  - State enum `md_state_t` (IDLE, RDREQ, RDLOAD, WRREQ).
  - Default timeout constant.
  - Counter width (16).
- Sub-module `md_parity`: 32-bit odd-parity generator, shared by the `md_par` and check logic, instantiated only under `MD_PARITY_EN`.

## Test plan
- **Read:** `memrd` at cycle 0, `bus_ack` at cycle 3 with bus = 0x12345678 → `loadmd` at cycle 4, `md` = 0x12345678 at cycle 5, `mwait` on `srcmd` during cycles 1–4.
- **Write:** `destmd` with `ob` = 0xDEADBEEF, then `memwr` → `memdrive`/`wrcyc` high until ack, `mds` = 0xDEADBEEF during WRREQ.
- **Timeout:** TIMEOUT = 4, `memrd` with no ack → `nxm` = 1 at the 5th cycle after `memrq`, `md` unchanged, state IDLE; `nxm_clr` clears it.
- **Simultaneous requests:** `memrd` & `memwr` in IDLE → read cycle only. `memwr` during RDREQ → `mwait` = 1 until it is accepted after RDLOAD.
- **Parity (`MD_PARITY_EN`):** read 0x00000001 with `bus_par` = 1 → `par_err` = 1 and `md_par` = 0. Read 0x00000003 with `bus_par` = 1 → no error.
- **Reset mid-read:** assert `reset_n` = 0 during RDREQ → `memrq` = 0 immediately, `md` = 0; after release a new `memrd` proceeds normally.
